mem_stage: RTL and testbench

- Memory stage of the single-issue pipeline; consumes the EX/MEM pipeline register driven by the execute stage.
- Performs load/store to data memory over a req/ack handshake, stalling upstream while an access is outstanding.
- Drives the MEM-stage forwarding values back to execute and the MEM/WB pipeline register.

---
 rtl/mem_stage.sv | 213 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. It runs loads and stores over a dmem req/ack handshake with a
// timeout, and drives the MEM forwarding values and the MEM/WB register. The optional posted store buffer is enabled by MEM_STORE_BUFFER_EN.
module mem_stage #(
   parameter int DMEM_TIMEOUT = 255
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] aluResult1_PR,
   input  logic [31:0] readDataB1_PR,
   input  logic        MemRead1_PR,
   input  logic        MemWrite1_PR,
   input  logic        MemtoReg1_PR,
   input  logic [2:0]  MemSize1_PR,
   input  logic [4:0]  writeRegister1_PR,
   input  logic        do_writeback1_PR,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        STALL_MEM,
   output logic [31:0] Data1_MEM,
   output logic [4:0]  writeRegister1_MEM,
   output logic        do_writeback1_MEM,
   output logic [31:0] Data1_WB,
   output logic [4:0]  writeRegister1_WB,
   output logic        do_writeback1_WB,
   output logic        mem_fault
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state_reg, state_next;
   logic [7:0]  tmo_cnt_reg;
   logic [31:0] load_data_reg;
   logic        fault_op_reg;

   logic        memop, is_byte, is_half, is_word, is_unsigned, misaligned;
   logic [31:0] word_addr, wdata_calc, load_ext, lane_data;
   logic [3:0]  be_calc;
   logic        timeout_hit, fault_this_op;
   logic        sb_free, start_post, start_access, start_fault;

   assign memop       = MemRead1_PR | MemWrite1_PR;
   assign is_byte     = (MemSize1_PR == 3'd0) || (MemSize1_PR == 3'd4);
   assign is_half     = (MemSize1_PR == 3'd1) || (MemSize1_PR == 3'd5);
   assign is_word     = !is_byte && !is_half;
   assign is_unsigned = (MemSize1_PR == 3'd4) || (MemSize1_PR == 3'd5);
   assign misaligned  = (is_half && aluResult1_PR[0]) || (is_word && (aluResult1_PR[1:0] != 2'b00));
   assign word_addr   = {aluResult1_PR[31:2], 2'b00};
   assign timeout_hit = (tmo_cnt_reg == 8'(DMEM_TIMEOUT - 1));
   assign fault_this_op = (state_reg == DONE) && fault_op_reg;

`ifdef MEM_STORE_BUFFER_EN
   logic        sb_valid_reg;
   logic [31:0] sb_addr_reg, sb_wdata_reg;
   logic [3:0]  sb_be_reg;

   assign sb_free    = !sb_valid_reg;
   assign start_post = (state_reg == IDLE) && MemWrite1_PR && !MemRead1_PR && !misaligned && sb_free;
`else
   assign sb_free    = 1'b1;
   assign start_post = 1'b0;
`endif

   assign start_access = (state_reg == IDLE) && memop && sb_free && !misaligned && !start_post;
   assign start_fault  = (state_reg == IDLE) && memop && sb_free && misaligned;

   always_comb begin
      be_calc    = 4'b1111;
      wdata_calc = readDataB1_PR;
      if (is_byte) begin
         be_calc    = 4'b0001 << aluResult1_PR[1:0];
         wdata_calc = {4{readDataB1_PR[7:0]}};
      end else if (is_half) begin
         be_calc    = 4'b0011 << aluResult1_PR[1:0];
         wdata_calc = {2{readDataB1_PR[15:0]}};
      end
   end

   // The PR address is held by the stall, so its low bits still select the lane at ack time.
   always_comb begin
      lane_data = dmem_rdata >> {aluResult1_PR[1:0], 3'b000};
      load_ext  = dmem_rdata;
      if (is_byte)
         load_ext = is_unsigned ? {24'h0, lane_data[7:0]} : {{24{lane_data[7]}}, lane_data[7:0]};
      else if (is_half)
         load_ext = is_unsigned ? {16'h0, lane_data[15:0]} : {{16{lane_data[15]}}, lane_data[15:0]};
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start_fault)
               state_next = DONE;
            else if (start_access)
               state_next = BUSY;
         end
         BUSY: begin
            if (dmem_ack || timeout_hit)
               state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         dmem_req      <= 1'b0;
         dmem_we       <= 1'b0;
         dmem_addr     <= 32'h0;
         dmem_wdata    <= 32'h0;
         dmem_be       <= 4'h0;
         tmo_cnt_reg   <= 8'h0;
         load_data_reg <= 32'h0;
         fault_op_reg  <= 1'b0;
         mem_fault     <= 1'b0;
`ifdef MEM_STORE_BUFFER_EN
         sb_valid_reg  <= 1'b0;
         sb_addr_reg   <= 32'h0;
         sb_wdata_reg  <= 32'h0;
         sb_be_reg     <= 4'h0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               fault_op_reg <= start_fault;
               if (start_fault)
                  mem_fault <= 1'b1;
               if (start_access) begin
                  dmem_req    <= 1'b1;
                  dmem_we     <= MemWrite1_PR;
                  dmem_addr   <= word_addr;
                  dmem_be     <= be_calc;
                  dmem_wdata  <= wdata_calc;
                  tmo_cnt_reg <= 8'h0;
               end
`ifdef MEM_STORE_BUFFER_EN
               else if (start_post) begin
                  sb_valid_reg <= 1'b1;
                  sb_addr_reg  <= word_addr;
                  sb_be_reg    <= be_calc;
                  sb_wdata_reg <= wdata_calc;
               end else if (sb_valid_reg) begin
                  // Drain runs while the main FSM idles; a pending memop waits on sb_free.
                  if (!dmem_req) begin
                     dmem_req    <= 1'b1;
                     dmem_we     <= 1'b1;
                     dmem_addr   <= sb_addr_reg;
                     dmem_be     <= sb_be_reg;
                     dmem_wdata  <= sb_wdata_reg;
                     tmo_cnt_reg <= 8'h0;
                  end else if (dmem_ack) begin
                     dmem_req     <= 1'b0;
                     sb_valid_reg <= 1'b0;
                  end else if (timeout_hit) begin
                     dmem_req     <= 1'b0;
                     sb_valid_reg <= 1'b0;
                     mem_fault    <= 1'b1;
                  end else begin
                     tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
                  end
               end
`endif
            end
            BUSY: begin
               if (dmem_ack) begin
                  dmem_req      <= 1'b0;
                  load_data_reg <= load_ext;
               end else if (timeout_hit) begin
                  dmem_req     <= 1'b0;
                  fault_op_reg <= 1'b1;
                  mem_fault    <= 1'b1;
               end else begin
                  tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign STALL_MEM          = memop && (state_reg != DONE) && !start_post;
   assign Data1_MEM          = MemtoReg1_PR ? load_data_reg : aluResult1_PR;
   assign writeRegister1_MEM = writeRegister1_PR;
   assign do_writeback1_MEM  = do_writeback1_PR && !(MemRead1_PR && (state_reg != DONE)) && !fault_this_op;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         Data1_WB          <= 32'h0;
         writeRegister1_WB <= 5'h0;
         do_writeback1_WB  <= 1'b0;
      end else if (STALL_MEM) begin
         do_writeback1_WB <= 1'b0;
      end else begin
         Data1_WB          <= Data1_MEM;
         writeRegister1_WB <= writeRegister1_PR;
         do_writeback1_WB  <= do_writeback1_MEM;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage (DMEM_TIMEOUT=4), default build without the store buffer.
module tb_mem_stage;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [31:0] aluResult1_PR, readDataB1_PR;
   logic        MemRead1_PR, MemWrite1_PR, MemtoReg1_PR;
   logic [2:0]  MemSize1_PR;
   logic [4:0]  writeRegister1_PR;
   logic        do_writeback1_PR;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        STALL_MEM;
   logic [31:0] Data1_MEM;
   logic [4:0]  writeRegister1_MEM;
   logic        do_writeback1_MEM;
   logic [31:0] Data1_WB;
   logic [4:0]  writeRegister1_WB;
   logic        do_writeback1_WB;
   logic        mem_fault;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        wb;
      logic        chk_data;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   mem_stage #(.DMEM_TIMEOUT(4)) dut (
      .CLK(CLK), .RESET(RESET),
      .aluResult1_PR(aluResult1_PR), .readDataB1_PR(readDataB1_PR),
      .MemRead1_PR(MemRead1_PR), .MemWrite1_PR(MemWrite1_PR), .MemtoReg1_PR(MemtoReg1_PR),
      .MemSize1_PR(MemSize1_PR), .writeRegister1_PR(writeRegister1_PR), .do_writeback1_PR(do_writeback1_PR),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .STALL_MEM(STALL_MEM), .Data1_MEM(Data1_MEM), .writeRegister1_MEM(writeRegister1_MEM),
      .do_writeback1_MEM(do_writeback1_MEM), .Data1_WB(Data1_WB), .writeRegister1_WB(writeRegister1_WB),
      .do_writeback1_WB(do_writeback1_WB), .mem_fault(mem_fault)
   );

   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive_pr(input logic [31:0] alu, input logic [31:0] bdata, input logic rd_en,
                           input logic wr_en, input logic m2r, input logic [2:0] size,
                           input logic [4:0] rd, input logic dowb);
      aluResult1_PR     = alu;
      readDataB1_PR     = bdata;
      MemRead1_PR       = rd_en;
      MemWrite1_PR      = wr_en;
      MemtoReg1_PR      = m2r;
      MemSize1_PR       = size;
      writeRegister1_PR = rd;
      do_writeback1_PR  = dowb;
   endtask

   // ack_at: BUSY cycle (1-based) carrying dmem_ack; 0 means the ack never comes.
   task automatic run_op(input string tag, input logic [31:0] alu, input logic [31:0] bdata,
                         input logic rd_en, input logic wr_en, input logic m2r, input logic [2:0] size,
                         input logic [4:0] rd, input logic dowb, input int ack_at, input logic [31:0] rdata,
                         input int exp_stall, input int exp_busy, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_data, input logic exp_wb,
                         input logic chk_data);
      int   stalls = 0;
      int   busy = 0;
      exp_t e;
      @(negedge CLK);
      drive_pr(alu, bdata, rd_en, wr_en, m2r, size, rd, dowb);
      exp_q.push_back('{data: exp_data, rd: rd, wb: exp_wb, chk_data: chk_data});
      #1;
      for (int i = 0; i < 400; i++) begin
         if (dmem_req) begin
            busy++;
            check_val({tag, "_addr"}, dmem_addr, {alu[31:2], 2'b00});
            check_val({tag, "_be"}, 32'(dmem_be), 32'(exp_be));
            check_val({tag, "_we"}, 32'(dmem_we), 32'(wr_en));
            check_val({tag, "_wdata"}, dmem_wdata, exp_wdata);
            if (busy == ack_at) begin
               dmem_ack   = 1'b1;
               dmem_rdata = rdata;
            end
         end
         if (!STALL_MEM) break;
         stalls++;
         @(negedge CLK);
         dmem_ack   = 1'b0;
         dmem_rdata = 32'h0;
         #1;
      end
      check_val({tag, "_stalls"}, 32'(stalls), 32'(exp_stall));
      check_val({tag, "_busy"}, 32'(busy), 32'(exp_busy));
      check_val({tag, "_req_off"}, 32'(dmem_req), 32'h0);
      if (chk_data) check_val({tag, "_fwd"}, Data1_MEM, exp_data);
      @(posedge CLK);
      #1;
      e = exp_q.pop_front();
      if (e.chk_data) check_val({tag, "_data_wb"}, Data1_WB, e.data);
      check_val({tag, "_rd_wb"}, 32'(writeRegister1_WB), 32'(e.rd));
      check_val({tag, "_wb_en"}, 32'(do_writeback1_WB), 32'(e.wb));
      $display("txn %-10s stalls=%0d busy=%0d data_wb=%h rd_wb=%0d wb=%0b fault=%0b",
               tag, stalls, busy, Data1_WB, writeRegister1_WB, do_writeback1_WB, mem_fault);
   endtask

   task automatic pulse_reset();
      @(negedge CLK);
      RESET = 1'b1;
      drive_pr(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0);
      @(negedge CLK);
      RESET = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET      = 1'b1;
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
      drive_pr(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0);
      repeat (2) @(negedge CLK);
      #1;
      check_val("rst_req", 32'(dmem_req), 32'h0);
      check_val("rst_be", 32'(dmem_be), 32'h0);
      check_val("rst_addr", dmem_addr, 32'h0);
      check_val("rst_data_wb", Data1_WB, 32'h0);
      check_val("rst_wb_en", 32'(do_writeback1_WB), 32'h0);
      check_val("rst_fault", 32'(mem_fault), 32'h0);
      RESET = 1'b0;

      //       tag      alu           bdata         rd wr m2r sz  rd  wb ack rdata         st bz be       wdata         data          wb chk
      run_op("alu",    32'h1234,     32'h0,        0, 0, 0, 3'd0, 5,  1, 0, 32'h0,        0, 0, 4'h0, 32'h0,        32'h1234,     1, 1);
      run_op("lb",     32'h101,      32'h0,        1, 0, 1, 3'd0, 7,  1, 1, 32'h8000,     2, 1, 4'h2, 32'h0,        32'hFFFFFF80, 1, 1);
      run_op("lbu",    32'h101,      32'h0,        1, 0, 1, 3'd4, 8,  1, 1, 32'h8000,     2, 1, 4'h2, 32'h0,        32'h00000080, 1, 1);
      run_op("lh",     32'h102,      32'h0,        1, 0, 1, 3'd1, 10, 1, 2, 32'h80010000, 3, 2, 4'hC, 32'h0,        32'hFFFF8001, 1, 1);
      run_op("lhu",    32'h104,      32'h0,        1, 0, 1, 3'd5, 11, 1, 1, 32'h1234ABCD, 2, 1, 4'h3, 32'h0,        32'h0000ABCD, 1, 1);
      run_op("sw",     32'h200,      32'hDEADBEEF, 0, 1, 0, 3'd2, 0,  0, 4, 32'h0,        5, 4, 4'hF, 32'hDEADBEEF, 32'h200,      0, 1);
      run_op("sb",     32'h203,      32'h123456A5, 0, 1, 0, 3'd0, 0,  0, 2, 32'h0,        3, 2, 4'h8, 32'hA5A5A5A5, 32'h203,      0, 1);
      run_op("lw",     32'h300,      32'h0,        1, 0, 1, 3'd2, 12, 1, 3, 32'hCAFEF00D, 4, 3, 4'hF, 32'h0,        32'hCAFEF00D, 1, 1);
      run_op("lw_r0",  32'h304,      32'h0,        1, 0, 1, 3'd2, 0,  1, 1, 32'h13572468, 2, 1, 4'hF, 32'h0,        32'h13572468, 1, 1);
      check_val("no_fault", 32'(mem_fault), 32'h0);

      run_op("lw_mis",  32'h202,     32'h0,        1, 0, 1, 3'd2, 9,  1, 1, 32'h0,        1, 0, 4'h0, 32'h0,        32'h0,        0, 0);
      check_val("mis_fault", 32'(mem_fault), 32'h1);
      run_op("lh_mis",  32'h101,     32'h0,        1, 0, 1, 3'd1, 9,  1, 1, 32'h0,        1, 0, 4'h0, 32'h0,        32'h0,        0, 0);
      run_op("alu2",    32'h77,      32'h0,        0, 0, 0, 3'd0, 6,  1, 0, 32'h0,        0, 0, 4'h0, 32'h0,        32'h77,       1, 1);
      check_val("fault_sticky", 32'(mem_fault), 32'h1);

      pulse_reset();
      #1;
      check_val("rst2_fault", 32'(mem_fault), 32'h0);
      run_op("lw_tmo",  32'h400,     32'h0,        1, 0, 1, 3'd2, 13, 1, 0, 32'h0,        5, 4, 4'hF, 32'h0,        32'h0,        0, 0);
      check_val("tmo_fault", 32'(mem_fault), 32'h1);
      run_op("alu3",    32'h55,      32'h0,        0, 0, 0, 3'd0, 3,  1, 0, 32'h0,        0, 0, 4'h0, 32'h0,        32'h55,       1, 1);

      // Reset in the middle of a BUSY access, followed by a stray ack.
      @(negedge CLK);
      drive_pr(32'h500, 32'h0, 1'b1, 1'b0, 1'b1, 3'd2, 5'd4, 1'b1);
      @(negedge CLK);
      #1;
      check_val("mid_req_on", 32'(dmem_req), 32'h1);
      RESET = 1'b1;
      #1;
      check_val("mid_req_drop", 32'(dmem_req), 32'h0);
      check_val("mid_data_wb", Data1_WB, 32'h0);
      check_val("mid_wb_en", 32'(do_writeback1_WB), 32'h0);
      check_val("mid_rd_wb", 32'(writeRegister1_WB), 32'h0);
      @(negedge CLK);
      RESET = 1'b0;
      drive_pr(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hFFFFFFFF;
      @(negedge CLK);
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
      #1;
      check_val("late_ack_req", 32'(dmem_req), 32'h0);
      check_val("late_ack_stall", 32'(STALL_MEM), 32'h0);
      check_val("late_ack_wb_en", 32'(do_writeback1_WB), 32'h0);
      check_val("late_ack_data", Data1_WB, 32'h0);
      run_op("lw_after", 32'h504,    32'h0,        1, 0, 1, 3'd2, 14, 1, 1, 32'h0BADC0DE, 2, 1, 4'hF, 32'h0,        32'h0BADC0DE, 1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
